multicycle_ctrl: RTL and testbench

//   Multi-cycle sequencer for the RV32I datapath (PC reg, instruction memory, sign extend, regfile, ALU).

---
 rtl/multicycle_ctrl.sv | 173 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC(/WB) sequencer for the RV32I datapath.
// It decodes addi and bne, and halts the core with an error code on an illegal opcode or a fetch timeout.
module multicycle_ctrl #(
    parameter int CNT_WIDTH     = 16,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 mem_ack,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 EQ,
    output logic                 mem_req,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 PCsrc,
    output logic                 RegWrite,
    output logic                 ALUctrl,
    output logic                 ALUsrc,
    output logic                 ImmSrc,
    output logic                 halted,
    output logic [1:0]           err,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam int WAIT_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_ADDI   = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_I,
        S_WB,
        S_EXEC_B,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_t;

    state_t                state_q, state_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    err_t                  err_q, err_d;
    logic                  retire_en;
    logic [CNT_WIDTH-1:0]  retired_q;

    // NOTE: state lives only in always_ff with non-blocking assignments; every
    // register here is reset asynchronously so outputs drop the instant rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Retired-instruction counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
        end else if (retire_en && (retired_q != '1)) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    // NOTE: every signal written below gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        err_d     = err_q;
        retire_en = 1'b0;
        mem_req   = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCsrc     = 1'b0;
        RegWrite  = 1'b0;
        ALUctrl   = 1'b0;
        ALUsrc    = 1'b0;
        ImmSrc    = 1'b0;
        halted    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                wait_d = '0;
                if (run) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                mem_req = 1'b1;
                // An ack on the last allowed cycle takes priority over the timeout.
                if (mem_ack) begin
                    IRWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_DECODE: begin
                wait_d = '0;
                if (opcode == OP_IMM && funct3 == F3_ADDI) begin
                    state_d = S_EXEC_I;
                end else if (opcode == OP_BRANCH && funct3 == F3_BNE) begin
                    state_d = S_EXEC_B;
                end else begin
                    state_d = S_HALT;
                    err_d   = ERR_ILLEGAL;
                end
            end

            S_EXEC_I: begin
                ALUsrc  = 1'b1;
                state_d = S_WB;
            end

            S_WB: begin
                ALUsrc    = 1'b1;
                RegWrite  = 1'b1;
                PCWrite   = 1'b1;
                retire_en = 1'b1;
                state_d   = run ? S_FETCH : S_IDLE;
            end

            S_EXEC_B: begin
                ALUctrl   = 1'b1;
                ImmSrc    = 1'b1;
                PCWrite   = 1'b1;
                PCsrc     = ~EQ;
                retire_en = 1'b1;
                state_d   = run ? S_FETCH : S_IDLE;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign err     = err_q;
    assign retired = retired_q;

    // The instruction-register load never overlaps a PC or regfile update.
    a_irwrite_alone: assert property (@(posedge clk) disable iff (rst)
        IRWrite |-> !(PCWrite || RegWrite));

    a_halt_has_err: assert property (@(posedge clk) disable iff (rst)
        halted |-> (err != 2'b00));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: reset, addi/bne sequencing, illegal opcode, fetch timeout, counter saturation.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst, run, mem_ack, EQ;
    logic [6:0] opcode;
    logic [2:0] funct3;

    logic        mem_req, IRWrite, PCWrite, PCsrc, RegWrite, ALUctrl, ALUsrc, ImmSrc, halted;
    logic [1:0]  err;
    logic [15:0] retired;

    logic        s_mem_req, s_IRWrite, s_PCWrite, s_PCsrc, s_RegWrite, s_ALUctrl, s_ALUsrc, s_ImmSrc, s_halted;
    logic [1:0]  s_err;
    logic [1:0]  s_retired;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    // Output vector bit positions: {mem_req,IRWrite,PCWrite,PCsrc,RegWrite,ALUctrl,ALUsrc,ImmSrc,halted}
    localparam logic [8:0] B_MEMREQ = 9'h100;
    localparam logic [8:0] B_IRW    = 9'h080;
    localparam logic [8:0] B_PCW    = 9'h040;
    localparam logic [8:0] B_PCSRC  = 9'h020;
    localparam logic [8:0] B_REGW   = 9'h010;
    localparam logic [8:0] B_ALUCTL = 9'h008;
    localparam logic [8:0] B_ALUSRC = 9'h004;
    localparam logic [8:0] B_IMMSRC = 9'h002;
    localparam logic [8:0] B_HALTED = 9'h001;

    localparam logic [8:0] V_ZERO   = 9'h000;
    localparam logic [8:0] V_FWAIT  = B_MEMREQ;
    localparam logic [8:0] V_FACK   = B_MEMREQ | B_IRW;
    localparam logic [8:0] V_EXI    = B_ALUSRC;
    localparam logic [8:0] V_WB     = B_PCW | B_REGW | B_ALUSRC;
    localparam logic [8:0] V_EXB_T  = B_PCW | B_PCSRC | B_ALUCTL | B_IMMSRC;
    localparam logic [8:0] V_EXB_NT = B_PCW | B_ALUCTL | B_IMMSRC;
    localparam logic [8:0] V_HALT   = B_HALTED;

    multicycle_ctrl #(.CNT_WIDTH(16), .FETCH_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .run(run), .mem_ack(mem_ack),
        .opcode(opcode), .funct3(funct3), .EQ(EQ),
        .mem_req(mem_req), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCsrc(PCsrc),
        .RegWrite(RegWrite), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc),
        .halted(halted), .err(err), .retired(retired)
    );

    multicycle_ctrl #(.CNT_WIDTH(2), .FETCH_TIMEOUT(15)) dut_sat (
        .clk(clk), .rst(rst), .run(run), .mem_ack(mem_ack),
        .opcode(opcode), .funct3(funct3), .EQ(EQ),
        .mem_req(s_mem_req), .IRWrite(s_IRWrite), .PCWrite(s_PCWrite), .PCsrc(s_PCsrc),
        .RegWrite(s_RegWrite), .ALUctrl(s_ALUctrl), .ALUsrc(s_ALUsrc), .ImmSrc(s_ImmSrc),
        .halted(s_halted), .err(s_err), .retired(s_retired)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {mem_req, IRWrite, PCWrite, PCsrc, RegWrite, ALUctrl, ALUsrc, ImmSrc, halted};
    endfunction

    function automatic logic [8:0] outs_sat();
        return {s_mem_req, s_IRWrite, s_PCWrite, s_PCsrc, s_RegWrite, s_ALUctrl, s_ALUsrc, s_ImmSrc, s_halted};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; run = 1'b0; mem_ack = 1'b0; EQ = 1'b0;
        opcode = OP_ADDI; funct3 = 3'b000;
        cyc(); cyc();
        check("rst_outs", 32'(outs()), 32'(V_ZERO));
        check("rst_err", 32'(err), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);

        // T2: addi with immediate ack
        rst = 1'b0; run = 1'b1; mem_ack = 1'b1; settle();
        check("post_rst_idle", 32'(outs()), 32'(V_ZERO));
        cyc(); check("t2_c1_fetch", 32'(outs()), 32'(V_FACK));
        cyc(); check("t2_c2_decode", 32'(outs()), 32'(V_ZERO));
        cyc(); check("t2_c3_exec_i", 32'(outs()), 32'(V_EXI));
        cyc(); check("t2_c4_wb", 32'(outs()), 32'(V_WB));
        check("t2_wb_retired_before", 32'(retired), 32'd0);

        // T3: bne, first not-equal (taken), then equal (not taken)
        cyc();
        opcode = OP_BRANCH; funct3 = 3'b001; EQ = 1'b0; settle();
        check("t2_retired", 32'(retired), 32'd1);
        check("t3a_fetch", 32'(outs()), 32'(V_FACK));
        cyc(); check("t3a_decode", 32'(outs()), 32'(V_ZERO));
        cyc(); check("t3a_exec_b_taken", 32'(outs()), 32'(V_EXB_T));
        cyc();
        EQ = 1'b1; settle();
        check("t3a_retired", 32'(retired), 32'd2);
        check("t3b_fetch", 32'(outs()), 32'(V_FACK));
        cyc(); check("t3b_decode", 32'(outs()), 32'(V_ZERO));
        cyc(); check("t3b_exec_b_not_taken", 32'(outs()), 32'(V_EXB_NT));

        // T1: reset pulse while in WB of a further addi
        cyc();
        opcode = OP_ADDI; funct3 = 3'b000; EQ = 1'b0; settle();
        check("t3b_retired", 32'(retired), 32'd3);
        cyc(); cyc(); cyc();
        check("t1_in_wb", 32'(outs()), 32'(V_WB));
        rst = 1'b1; settle();
        check("t1_rst_outs", 32'(outs()), 32'(V_ZERO));
        check("t1_rst_retired", 32'(retired), 32'd0);
        check("t1_rst_err", 32'(err), 32'd0);
        run = 1'b0;
        cyc();
        rst = 1'b0; settle();
        check("t1_first_after_rst", 32'(outs()), 32'(V_ZERO));
        cyc(); check("t1_idle_hold", 32'(outs()), 32'(V_ZERO));

        // T5a: no ack -> timeout after 15 FETCH cycles
        run = 1'b1; mem_ack = 1'b0; settle();
        check("t5a_idle", 32'(outs()), 32'(V_ZERO));
        for (int i = 1; i <= 15; i++) begin
            cyc();
            check($sformatf("t5a_fetch%0d", i), 32'(outs()), 32'(V_FWAIT));
        end
        check("t5a_err_before", 32'(err), 32'd0);
        cyc();
        check("t5a_halt", 32'(outs()), 32'(V_HALT));
        check("t5a_err", 32'(err), 32'd2);

        // T5b: ack on the 15th FETCH cycle wins over the timeout
        rst = 1'b1; settle();
        check("t5b_rst_err", 32'(err), 32'd0);
        cyc();
        rst = 1'b0; settle();
        check("t5b_idle", 32'(outs()), 32'(V_ZERO));
        for (int i = 1; i <= 14; i++) begin
            cyc();
            check($sformatf("t5b_fetch%0d", i), 32'(outs()), 32'(V_FWAIT));
        end
        cyc();
        mem_ack = 1'b1; settle();
        check("t5b_fetch15_ack", 32'(outs()), 32'(V_FACK));
        cyc();
        check("t5b_decode", 32'(outs()), 32'(V_ZERO));
        check("t5b_decode_err", 32'(err), 32'd0);
        cyc(); check("t5b_exec_i", 32'(outs()), 32'(V_EXI));
        cyc(); check("t5b_wb", 32'(outs()), 32'(V_WB));

        // T4: illegal opcode halts; run is ignored afterwards
        cyc();
        opcode = OP_RTYPE; funct3 = 3'b000; settle();
        check("t4_fetch", 32'(outs()), 32'(V_FACK));
        check("t4_retired_before", 32'(retired), 32'd1);
        cyc(); check("t4_decode", 32'(outs()), 32'(V_ZERO));
        cyc();
        check("t4_halt", 32'(outs()), 32'(V_HALT));
        check("t4_err", 32'(err), 32'd1);
        for (int i = 1; i <= 20; i++) begin
            cyc();
            check($sformatf("t4_halt_hold%0d", i), 32'(outs()), 32'(V_HALT));
        end
        check("t4_retired_after", 32'(retired), 32'd1);
        check("t4_err_after", 32'(err), 32'd1);

        // T6: five back-to-back addi on the 2-bit counter; run drops in the 5th EXEC_I
        rst = 1'b1; settle();
        opcode = OP_ADDI; funct3 = 3'b000; run = 1'b1; mem_ack = 1'b1;
        cyc();
        rst = 1'b0; settle();
        check("t6_idle", 32'(outs_sat()), 32'(V_ZERO));
        for (int n = 1; n <= 5; n++) begin
            int exp_cnt;
            exp_cnt = (n - 1 > 3) ? 3 : n - 1;
            cyc();
            check($sformatf("t6_fetch%0d", n), 32'(outs_sat()), 32'(V_FACK));
            check($sformatf("t6_retired%0d", n), 32'(s_retired), 32'(exp_cnt));
            cyc();
            cyc();
            if (n == 5) begin
                run = 1'b0;
                settle();
            end
            check($sformatf("t6_exec_i%0d", n), 32'(outs_sat()), 32'(V_EXI));
            cyc();
            check($sformatf("t6_wb%0d", n), 32'(outs_sat()), 32'(V_WB));
        end
        cyc();
        check("t6_idle_after", 32'(outs_sat()), 32'(V_ZERO));
        check("t6_retired_sat", 32'(s_retired), 32'd3);
        check("t6_retired_wide", 32'(retired), 32'd5);
        check("t6_err", 32'(s_err), 32'd0);
        cyc();
        check("t6_idle_hold", 32'(outs_sat()), 32'(V_ZERO));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
